// File: rtl/rom_port_arbiter.sv
// Boot ROM read-port arbiter: data-first priority with fetch starvation guard.
// One-cycle registered responses; range/alignment errors return safe data.
module rom_port_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] ROM_BASE  = 32'hBFC00000,
  parameter logic [ADDRESS_WIDTH-1:0] ROM_LIMIT = 32'hBFC00FFF,
  parameter int unsigned STARVE_MAX    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  input  logic                     if_flush,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  output logic                     if_err,
  input  logic                     d_req,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic                     d_err,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_dout
);

  localparam int CW = 4;
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h00000013);

  logic [CW-1:0]            starve_q;
  logic [ADDRESS_WIDTH-1:0] gnt_addr;
  logic [ADDRESS_WIDTH:0]   end_addr;
  logic                     gnt_err;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (if_req && d_req) begin
        if (starve_q == SMAX) if_gnt = 1'b1;
        else                  d_gnt  = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_addr = d_addr;
    rom_addr = ROM_BASE;
    unique case (1'b1)
      if_gnt: begin
        gnt_addr = if_addr;
        rom_addr = {if_addr[ADDRESS_WIDTH-1:2], 2'b00};
      end
      d_gnt: begin
        gnt_addr = d_addr;
        rom_addr = {d_addr[ADDRESS_WIDTH-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  // Extra bit keeps the end-of-word compare from wrapping near the top.
  assign end_addr = {1'b0, gnt_addr} + (ADDRESS_WIDTH+1)'(3);
  assign gnt_err  = (gnt_addr < ROM_BASE)
                 || (end_addr > {1'b0, ROM_LIMIT})
                 || (gnt_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      starve_q  <= '0;
    end else begin
      if_rvalid <= if_gnt && !if_flush;
      d_rvalid  <= d_gnt;
      if (if_gnt) begin
        if_err   <= gnt_err;
        if_rdata <= (gnt_err || rom_dout == '0) ? NOP : rom_dout;
      end
      if (d_gnt) begin
        d_err   <= gnt_err;
        d_rdata <= gnt_err ? '0 : rom_dout;
      end
      if (if_req && !if_gnt) begin
        if (starve_q != SMAX) starve_q <= starve_q + 1'b1;
      end else begin
        starve_q <= '0;
      end
    end
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
Shares the single combinational read port of the boot ROM (0xBFC00000–0xBFC00FFF) between the instruction-fetch stage and the data-memory stage, which performs constant/table loads from ROM. Arbitration is fixed-priority data-first, with a starvation counter that guarantees fetch progress. Responses are registered with a fixed 1-cycle latency. Out-of-range and misaligned accesses return an error flag and safe data.

Parameters:
ADDRESS_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of the read word returned to requesters
ROM_BASE, 32'hBFC00000, first valid byte address
ROM_LIMIT, 32'hBFC00FFF, last valid byte address
STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win (range 1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDRESS_WIDTH  fetch byte address
if_flush  in  1  branch redirect; squashes the fetch response of a grant issued this cycle
if_gnt  out  1  fetch request accepted this cycle (combinational)
if_rvalid  out  1  fetch response valid (registered)
if_rdata  out  DATA_WIDTH  fetch word
if_err  out  1  fetch address out of range or misaligned; qualified by if_rvalid
d_req  in  1  data read request; held with d_addr stable until d_gnt
d_addr  in  ADDRESS_WIDTH  data byte address
d_gnt  out  1  data request accepted this cycle (combinational)
d_rvalid  out  1  data response valid (registered)
d_rdata  out  DATA_WIDTH  data word
d_err  out  1  data address error; qualified by d_rvalid
rom_addr  out  ADDRESS_WIDTH  address driven to the ROM (combinational, muxed)
rom_dout  in  DATA_WIDTH  ROM read word (combinational from rom_addr)

Behaviour:
- Reset (rst=1 at a clock edge): if_rvalid, d_rvalid, if_err, d_err = 0; if_rdata, d_rdata = 0; starve counter = 0. While rst=1, if_gnt = d_gnt = 0 and rom_addr = ROM_BASE.
- A reset asserted mid-operation drops any pending response; no rvalid is produced for a grant made in the reset cycle.
- Grant rules, evaluated each cycle. At most one grant per cycle:
  - only one request active: that requester is granted;
  - both active and starve counter < STARVE_MAX: d_gnt = 1;
  - both active and starve counter == STARVE_MAX: if_gnt = 1.
- rom_addr = granted address with bits [1:0] forced to 0. When no request is granted, rom_addr = ROM_BASE.
- Starve counter:
  - increments (saturating at STARVE_MAX) in any cycle with if_req=1 and if_gnt=0;
  - clears to 0 on if_gnt=1 or if_req=0.
- Latency: a grant in cycle N produces rvalid=1 for exactly one cycle in N+1, with rdata registered from rom_dout in cycle N.
- Grants may issue every cycle, so fully pipelined back-to-back reads give one response per cycle.
- Address check, on the granted address in cycle N:
  - error if address < ROM_BASE, address + 3 > ROM_LIMIT, or address[1:0] != 0;
  - on error, err=1 at N+1;
  - if_rdata = 32'h00000013 (NOP), d_rdata = 0;
  - ROM data is discarded.
- Zero substitution: a valid fetch returning rom_dout == 0 delivers 32'h00000013. Data reads deliver 0 unmodified.
- Flush:
  - if_flush=1 in the cycle of an if_gnt suppresses if_rvalid in N+1 (rdata/err may update but are unqualified);
  - if_flush does not block the grant itself and does not affect the data side.
- Response registers hold their last value when rvalid=0.

Test Plan:
1. Reset, then if_req=1, if_addr=0xBFC00000, d_req=0 → if_gnt=1 in cycle 0; at cycle 1: if_rvalid=1, if_rdata=ROM word at 0xBFC00000, if_err=0.
2. if_req and d_req both held high continuously with STARVE_MAX=4 → d_gnt for 4 cycles, if_gnt on the 5th, d_gnt again on the 6th; starve counter returns to 0 after the fetch grant.
3. d_req=1, d_addr=0xBFC01000 → d_gnt=1; next cycle d_rvalid=1, d_err=1, d_rdata=0. Repeat with d_addr=0xBFC00002 → same error result.
4. Fetch from an address whose ROM word is 0x00000000 → if_rdata=0x00000013, if_err=0. Fetch from 0x00001000 → if_err=1, if_rdata=0x00000013.
5. Fetch granted in cycle N with if_flush=1 → if_rvalid=0 at N+1. A fetch granted at N+1 with if_flush=0 → if_rvalid=1 at N+2.
6. Back-to-back fetches to 0xBFC00000, 0xBFC00004, 0xBFC00008, with rst=1 asserted in the third grant cycle → first two responses delivered on consecutive cycles, no third response, all outputs zero after the reset edge.
